// File: rtl/stage_tl_pkg.sv
// Shared types for the translation stage: datapath words, page numbers and DTLB entries.
// Imported by the EXTL/TLC interface, the DTLB and the stage top.
package stage_tl_pkg;

  localparam int WORD_BITS    = 32;
  localparam int PAGE_BITS    = 12;
  localparam int VPN_BITS     = WORD_BITS - PAGE_BITS;
  localparam int PPN_BITS_DEF = 8;
  // Stored ppn is sized for the widest physical space; an instance keeps only its low PPN_BITS.
  localparam int PPN_MAX      = 20;

  typedef logic [WORD_BITS-1:0]              word_t;
  typedef logic [WORD_BITS-1:0]              vptr_t;
  typedef logic [4:0]                        regid_t;
  typedef logic [1:0]                        threadid_t;
  typedef logic [VPN_BITS-1:0]               vpn_t;
  typedef logic [PPN_MAX-1:0]                ppn_t;
  typedef logic [PPN_BITS_DEF+PAGE_BITS-1:0] pptr_t;

  typedef enum logic [1:0] {
    TLBW_OFF  = 2'd0,
    TLBW_ITLB = 2'd1,
    TLBW_DTLB = 2'd2
  } tlbwrite_t;

  typedef struct packed {
    logic valid;
    vpn_t vpn;
    ppn_t ppn;
  } dtlb_entry_t;

  function automatic vpn_t vpn_of(input vptr_t addr);
    return addr[WORD_BITS-1:PAGE_BITS];
  endfunction

endpackage

// File: rtl/stage_tl_if.sv
// EXTL (into the translation stage) and TLC (into the cache stage) signal bundle.
// master = surrounding pipeline, slave = stage_tl.
interface stage_tl_if
  import stage_tl_pkg::*;
#(
  parameter int PPN_BITS = PPN_BITS_DEF
);

  threadid_t tl_thread;
  logic      tl_isvalid;
  logic      tl_itlb_miss;
  vptr_t     tl_pc;
  word_t     tl_data;
  word_t     tl_mul;
  word_t     tl_r2;
  regid_t    tl_dst;
  logic      tl_isequal;
  logic      tl_flag_mem;
  logic      tl_flag_store;
  logic      tl_flag_isbyte;
  logic      tl_flag_mul;
  logic      tl_flag_reg;
  logic      tl_flag_jump;
  logic      tl_flag_branch;
  logic      tl_flag_iret;
  tlbwrite_t tl_flag_tlbwrite;
  logic      tl_priv;
  logic      c_stall;
  logic      tl_flush;

  threadid_t                     c_thread;
  logic                          c_isvalid;
  logic                          c_itlb_miss;
  vptr_t                         c_pc;
  word_t                         c_data;
  word_t                         c_mul;
  word_t                         c_r2;
  regid_t                        c_dst;
  logic [PPN_BITS+PAGE_BITS-1:0] c_paddr;
  logic                          c_dtlb_miss;
  logic                          c_flag_mem;
  logic                          c_flag_store;
  logic                          c_flag_isbyte;
  logic                          c_flag_mul;
  logic                          c_flag_reg;
  logic                          c_flag_iret;
  logic                          c_redirect;
  vptr_t                         c_redirect_pc;

  modport master (
    output tl_thread, tl_isvalid, tl_itlb_miss, tl_pc, tl_data, tl_mul, tl_r2, tl_dst,
           tl_isequal, tl_flag_mem, tl_flag_store, tl_flag_isbyte, tl_flag_mul, tl_flag_reg,
           tl_flag_jump, tl_flag_branch, tl_flag_iret, tl_flag_tlbwrite, tl_priv,
           c_stall, tl_flush,
    input  c_thread, c_isvalid, c_itlb_miss, c_pc, c_data, c_mul, c_r2, c_dst, c_paddr,
           c_dtlb_miss, c_flag_mem, c_flag_store, c_flag_isbyte, c_flag_mul, c_flag_reg,
           c_flag_iret, c_redirect, c_redirect_pc
  );

  modport slave (
    input  tl_thread, tl_isvalid, tl_itlb_miss, tl_pc, tl_data, tl_mul, tl_r2, tl_dst,
           tl_isequal, tl_flag_mem, tl_flag_store, tl_flag_isbyte, tl_flag_mul, tl_flag_reg,
           tl_flag_jump, tl_flag_branch, tl_flag_iret, tl_flag_tlbwrite, tl_priv,
           c_stall, tl_flush,
    output c_thread, c_isvalid, c_itlb_miss, c_pc, c_data, c_mul, c_r2, c_dst, c_paddr,
           c_dtlb_miss, c_flag_mem, c_flag_store, c_flag_isbyte, c_flag_mul, c_flag_reg,
           c_flag_iret, c_redirect, c_redirect_pc
  );

endinterface

// File: rtl/stage_tl_dtlb.sv
// Fully-associative data TLB: combinational lookup, one write port, round-robin victim.
// A write always targets the page being looked up, so both share the vpn input.
module stage_tl_dtlb
  import stage_tl_pkg::*;
#(
  parameter int DTLB_ENTRIES = 4,
  parameter int PPN_BITS     = PPN_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  vpn_t                vpn,
  output logic                hit,
  output logic [PPN_BITS-1:0] hit_ppn,
  input  logic                we,
  input  logic [PPN_BITS-1:0] wr_ppn
);

  localparam int IDX_BITS = (DTLB_ENTRIES > 1) ? $clog2(DTLB_ENTRIES) : 1;
  typedef logic [IDX_BITS-1:0] idx_t;

  dtlb_entry_t             entries [DTLB_ENTRIES];
  idx_t                    rr;
  logic [DTLB_ENTRIES-1:0] match;
  logic                    any_free;
  idx_t                    match_idx;
  idx_t                    free_idx;
  idx_t                    wr_idx;

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    match     = '0;
    any_free  = 1'b0;
    match_idx = '0;
    free_idx  = '0;
    for (int i = 0; i < DTLB_ENTRIES; i++) begin
      match[i] = entries[i].valid && (entries[i].vpn == vpn);
    end
    // Walking downward leaves the lowest index standing for both searches.
    for (int i = DTLB_ENTRIES - 1; i >= 0; i--) begin
      if (match[i]) match_idx = idx_t'(i);
      if (!entries[i].valid) begin
        free_idx = idx_t'(i);
        any_free = 1'b1;
      end
    end
    hit     = |match;
    hit_ppn = entries[match_idx].ppn[PPN_BITS-1:0];
    if (hit)           wr_idx = match_idx;
    else if (any_free) wr_idx = free_idx;
    else               wr_idx = rr;
  end

  // NOTE: only valid bits and rr are reset; vpn/ppn contents are never observed while invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr <= '0;
      for (int i = 0; i < DTLB_ENTRIES; i++) entries[i].valid <= 1'b0;
    end else if (we) begin
      entries[wr_idx] <= '{valid: 1'b1, vpn: vpn, ppn: ppn_t'(wr_ppn)};
      if (!hit && !any_free) rr <= rr + 1'b1;
    end
  end

endmodule

// File: rtl/stage_tl.sv
// Translation stage: EX results in, DTLB translation, DTLB writes and branch resolution,
// registered onto the TLC interface with one cycle of latency.
module stage_tl
  import stage_tl_pkg::*;
#(
  parameter int DTLB_ENTRIES = 4,
  parameter int PPN_BITS     = PPN_BITS_DEF
) (
  input logic       clk,
  input logic       rst,
  stage_tl_if.slave bus
);

  localparam int PPTR_BITS = PPN_BITS + PAGE_BITS;

  logic                 hit;
  logic [PPN_BITS-1:0]  hit_ppn;
  logic                 commit;
  logic                 dtlb_miss;
  logic                 taken;
  logic                 live;
  logic [PPTR_BITS-1:0] paddr;

  assign commit = bus.tl_isvalid && !bus.c_stall && !bus.tl_flush &&
                  (bus.tl_flag_tlbwrite == TLBW_DTLB);

  stage_tl_dtlb #(
    .DTLB_ENTRIES (DTLB_ENTRIES),
    .PPN_BITS     (PPN_BITS)
  ) u_dtlb (
    .clk     (clk),
    .rst     (rst),
    .vpn     (vpn_of(bus.tl_data)),
    .hit     (hit),
    .hit_ppn (hit_ppn),
    .we      (commit),
    .wr_ppn  (bus.tl_r2[PPN_BITS-1:0])
  );

  always_comb begin
    live      = bus.tl_isvalid && !bus.tl_flush;
    dtlb_miss = bus.tl_isvalid && bus.tl_flag_mem && !bus.tl_priv && !hit;
    taken     = bus.tl_isvalid &&
                (bus.tl_flag_jump || (bus.tl_flag_branch && bus.tl_isequal) || bus.tl_flag_iret);
    if (bus.tl_priv)  paddr = bus.tl_data[PPTR_BITS-1:0];
    else if (hit)     paddr = {hit_ppn, bus.tl_data[PAGE_BITS-1:0]};
    else              paddr = '0;
  end

  // NOTE: all pipeline state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.c_thread      <= '0;
      bus.c_isvalid     <= 1'b0;
      bus.c_itlb_miss   <= 1'b0;
      bus.c_pc          <= '0;
      bus.c_data        <= '0;
      bus.c_mul         <= '0;
      bus.c_r2          <= '0;
      bus.c_dst         <= '0;
      bus.c_paddr       <= '0;
      bus.c_dtlb_miss   <= 1'b0;
      bus.c_flag_mem    <= 1'b0;
      bus.c_flag_store  <= 1'b0;
      bus.c_flag_isbyte <= 1'b0;
      bus.c_flag_mul    <= 1'b0;
      bus.c_flag_reg    <= 1'b0;
      bus.c_flag_iret   <= 1'b0;
      bus.c_redirect    <= 1'b0;
      bus.c_redirect_pc <= '0;
    end else if (!bus.c_stall) begin
      bus.c_thread      <= bus.tl_thread;
      bus.c_isvalid     <= live;
      bus.c_itlb_miss   <= bus.tl_itlb_miss;
      bus.c_pc          <= bus.tl_pc;
      bus.c_data        <= bus.tl_data;
      bus.c_mul         <= bus.tl_mul;
      bus.c_r2          <= bus.tl_r2;
      bus.c_dst         <= bus.tl_dst;
      bus.c_paddr       <= paddr;
      bus.c_dtlb_miss   <= dtlb_miss && !bus.tl_flush;
      bus.c_flag_mem    <= bus.tl_flag_mem && live;
      bus.c_flag_store  <= bus.tl_flag_store && live;
      bus.c_flag_isbyte <= bus.tl_flag_isbyte && live;
      bus.c_flag_mul    <= bus.tl_flag_mul && live;
      bus.c_flag_reg    <= bus.tl_flag_reg && live;
      bus.c_flag_iret   <= bus.tl_flag_iret && live;
      bus.c_redirect    <= taken && !bus.tl_flush;
      // A flushed branch is treated as not taken, so its target reads as zero too.
      bus.c_redirect_pc <= (taken && !bus.tl_flush) ? bus.tl_data : '0;
    end else if (bus.tl_flush) begin
      // Stalled and flushed: kill the held instruction, keep the rest of the payload.
      bus.c_isvalid     <= 1'b0;
      bus.c_flag_mem    <= 1'b0;
      bus.c_flag_store  <= 1'b0;
      bus.c_flag_isbyte <= 1'b0;
      bus.c_flag_mul    <= 1'b0;
      bus.c_flag_reg    <= 1'b0;
      bus.c_flag_iret   <= 1'b0;
      bus.c_redirect    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stage_tl.sv
// Directed plus randomized bench for stage_tl against a page-table style reference model.
// The model keeps a small map of vpn->ppn with a replacement cursor and the expected TLC register.
module tb_stage_tl;
  import stage_tl_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stage_tl_if #(.PPN_BITS(PPN_BITS_DEF)) bus ();

  stage_tl #(.DTLB_ENTRIES(N), .PPN_BITS(PPN_BITS_DEF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    threadid_t thread;
    logic      isvalid;
    logic      itlb_miss;
    vptr_t     pc;
    word_t     data;
    word_t     mul;
    word_t     r2;
    regid_t    dst;
    pptr_t     paddr;
    logic      dtlb_miss;
    logic      mem, store, isbyte, mulf, regf, iret;
    logic      redirect;
    vptr_t     redirect_pc;
  } out_t;

  out_t          exp_q = '0;
  bit            m_valid [N];
  logic [19:0]   m_vpn   [N];
  logic [7:0]    m_ppn   [N];
  int            m_rr = 0;
  int            n_vec = 0;
  int            n_chk = 0;
  int            n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int model_find(input logic [19:0] v);
    for (int i = 0; i < N; i++) if (m_valid[i] && m_vpn[i] == v) return i;
    return -1;
  endfunction

  task automatic model_write(input logic [19:0] v, input logic [7:0] p);
    int idx;
    idx = model_find(v);
    if (idx < 0) for (int i = N - 1; i >= 0; i--) if (!m_valid[i]) idx = i;
    if (idx < 0) begin
      idx  = m_rr;
      m_rr = (m_rr + 1) % N;
    end
    m_valid[idx] = 1'b1;
    m_vpn[idx]   = v;
    m_ppn[idx]   = p;
  endtask

  task automatic compare_all();
    check("thread",      bus.c_thread,      exp_q.thread);
    check("isvalid",     bus.c_isvalid,     exp_q.isvalid);
    check("itlb_miss",   bus.c_itlb_miss,   exp_q.itlb_miss);
    check("pc",          bus.c_pc,          exp_q.pc);
    check("data",        bus.c_data,        exp_q.data);
    check("mul",         bus.c_mul,         exp_q.mul);
    check("r2",          bus.c_r2,          exp_q.r2);
    check("dst",         bus.c_dst,         exp_q.dst);
    check("paddr",       bus.c_paddr,       exp_q.paddr);
    check("dtlb_miss",   bus.c_dtlb_miss,   exp_q.dtlb_miss);
    check("flags",
          {bus.c_flag_mem, bus.c_flag_store, bus.c_flag_isbyte, bus.c_flag_mul, bus.c_flag_reg, bus.c_flag_iret},
          {exp_q.mem, exp_q.store, exp_q.isbyte, exp_q.mulf, exp_q.regf, exp_q.iret});
    check("redirect",    bus.c_redirect,    exp_q.redirect);
    check("redirect_pc", bus.c_redirect_pc, exp_q.redirect_pc);
  endtask

  // Predict the register contents after the next edge, clock it, then compare.
  task automatic step();
    out_t        nx;
    int          h;
    bit          live, miss, tk;
    logic [19:0] v;
    nx   = exp_q;
    v    = bus.tl_data[31:12];
    h    = model_find(v);
    live = bus.tl_isvalid && !bus.tl_flush;
    miss = bus.tl_isvalid && bus.tl_flag_mem && !bus.tl_priv && (h < 0);
    tk   = bus.tl_isvalid && (bus.tl_flag_jump || (bus.tl_flag_branch && bus.tl_isequal) || bus.tl_flag_iret);
    if (rst) begin
      nx   = '0;
      m_rr = 0;
      for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    end else begin
      if (!bus.c_stall) begin
        nx.thread    = bus.tl_thread;
        nx.isvalid   = live;
        nx.itlb_miss = bus.tl_itlb_miss;
        nx.pc        = bus.tl_pc;
        nx.data      = bus.tl_data;
        nx.mul       = bus.tl_mul;
        nx.r2        = bus.tl_r2;
        nx.dst       = bus.tl_dst;
        if (bus.tl_priv)  nx.paddr = bus.tl_data[19:0];
        else if (h >= 0)  nx.paddr = {m_ppn[h], bus.tl_data[11:0]};
        else              nx.paddr = '0;
        nx.dtlb_miss   = miss && !bus.tl_flush;
        nx.mem         = bus.tl_flag_mem && live;
        nx.store       = bus.tl_flag_store && live;
        nx.isbyte      = bus.tl_flag_isbyte && live;
        nx.mulf        = bus.tl_flag_mul && live;
        nx.regf        = bus.tl_flag_reg && live;
        nx.iret        = bus.tl_flag_iret && live;
        nx.redirect    = tk && !bus.tl_flush;
        nx.redirect_pc = nx.redirect ? bus.tl_data : 32'h0;
      end else if (bus.tl_flush) begin
        nx.isvalid  = 1'b0;
        nx.redirect = 1'b0;
        {nx.mem, nx.store, nx.isbyte, nx.mulf, nx.regf, nx.iret} = '0;
      end
      if (bus.tl_isvalid && !bus.c_stall && !bus.tl_flush && bus.tl_flag_tlbwrite == TLBW_DTLB)
        model_write(v, bus.tl_r2[7:0]);
    end
    @(posedge clk);
    #1;
    exp_q = nx;
    n_vec++;
    compare_all();
  endtask

  task automatic idle();
    bus.tl_thread = '0;      bus.tl_isvalid = 1'b0;   bus.tl_itlb_miss = 1'b0;
    bus.tl_pc = '0;          bus.tl_data = '0;        bus.tl_mul = '0;
    bus.tl_r2 = '0;          bus.tl_dst = '0;         bus.tl_isequal = 1'b0;
    bus.tl_flag_mem = 1'b0;  bus.tl_flag_store = 1'b0; bus.tl_flag_isbyte = 1'b0;
    bus.tl_flag_mul = 1'b0;  bus.tl_flag_reg = 1'b0;  bus.tl_flag_jump = 1'b0;
    bus.tl_flag_branch = 1'b0; bus.tl_flag_iret = 1'b0;
    bus.tl_flag_tlbwrite = TLBW_OFF; bus.tl_priv = 1'b0;
    bus.c_stall = 1'b0;      bus.tl_flush = 1'b0;
  endtask

  task automatic set_load(input word_t a, input bit priv);
    idle();
    bus.tl_isvalid = 1'b1; bus.tl_flag_mem = 1'b1; bus.tl_flag_reg = 1'b1;
    bus.tl_data = a;       bus.tl_priv = priv;     bus.tl_pc = 32'h400 + a[7:0];
    bus.tl_dst = 5'd3;     bus.tl_thread = 2'd1;
  endtask

  task automatic set_wr(input word_t a, input word_t p);
    idle();
    bus.tl_isvalid = 1'b1; bus.tl_flag_tlbwrite = TLBW_DTLB;
    bus.tl_data = a;       bus.tl_r2 = p;
  endtask

  initial begin
    pptr_t held_paddr;
    idle();
    rst = 1'b1;
    step();
    step();
    check("reset_isvalid", bus.c_isvalid, 1'b0);
    check("reset_paddr",   bus.c_paddr,   20'h0);
    rst = 1'b0;

    // Cold miss, then map the page and hit.
    set_load(32'h0000_5ABC, 1'b0); step();
    check("cold_miss", bus.c_dtlb_miss, 1'b1);
    check("cold_paddr", bus.c_paddr, 20'h0);
    set_wr(32'h0000_5000, 32'h3C); step();
    set_load(32'h0000_5ABC, 1'b0); step();
    check("hit_paddr", bus.c_paddr, 20'h3CABC);
    check("hit_miss", bus.c_dtlb_miss, 1'b0);

    // Fill and replacement order from a clean table.
    rst = 1'b1; idle(); step(); rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      set_wr(i << 12, 32'h10 + i); step();
    end
    set_load(32'h0000_1004, 1'b0); step();
    check("evicted_vpn1", bus.c_dtlb_miss, 1'b1);
    set_load(32'h0000_5004, 1'b0); step();
    check("vpn5_paddr", bus.c_paddr, 20'h15004);
    set_wr(32'h0000_3000, 32'h77); step();
    set_load(32'h0000_3008, 1'b0); step();
    check("rewrite_vpn3", bus.c_paddr, 20'h77008);
    set_wr(32'h0000_6000, 32'h66); step();
    set_load(32'h0000_2000, 1'b0); step();
    check("evicted_vpn2", bus.c_dtlb_miss, 1'b1);
    set_load(32'h0000_4010, 1'b0); step();
    check("vpn4_kept", bus.c_paddr, 20'h14010);

    // Stalled write: outputs frozen, one commit when the stall drops.
    held_paddr = exp_q.paddr;
    set_wr(32'h0000_9000, 32'h99);
    bus.c_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_frozen", bus.c_paddr, held_paddr);
    end
    bus.c_stall = 1'b0; step();
    set_load(32'h0000_9123, 1'b0); step();
    check("stall_commit", bus.c_paddr, 20'h99123);

    // Stall with flush: instruction killed, payload held, write dropped.
    set_wr(32'h0000_A000, 32'hAA);
    bus.c_stall = 1'b1; bus.tl_flush = 1'b1; step();
    check("sf_isvalid", bus.c_isvalid, 1'b0);
    check("sf_paddr", bus.c_paddr, 20'h99123);
    set_load(32'h0000_A000, 1'b0); step();
    check("sf_no_write", bus.c_dtlb_miss, 1'b1);

    // Branch taken, then flushed.
    idle(); bus.tl_isvalid = 1'b1; bus.tl_flag_branch = 1'b1; bus.tl_isequal = 1'b1;
    bus.tl_data = 32'h1000; step();
    check("br_redirect", bus.c_redirect, 1'b1);
    check("br_pc", bus.c_redirect_pc, 32'h1000);
    bus.tl_flush = 1'b1; step();
    check("br_flush_redirect", bus.c_redirect, 1'b0);
    check("br_flush_valid", bus.c_isvalid, 1'b0);

    // Supervisor bypass.
    set_load(32'hFFF0_1234, 1'b1); step();
    check("priv_paddr", bus.c_paddr, 20'h01234);
    check("priv_miss", bus.c_dtlb_miss, 1'b0);

    // Randomized traffic over a small page set so hits, misses and evictions all occur.
    for (int n = 0; n < 400; n++) begin
      idle();
      bus.tl_isvalid     = ($urandom_range(0, 9) < 8);
      bus.tl_thread      = 2'($urandom);
      bus.tl_itlb_miss   = 1'($urandom);
      bus.tl_pc          = $urandom;
      bus.tl_data        = {12'h0, 4'($urandom_range(0, 7)), 16'($urandom)};
      if ($urandom_range(0, 9) == 0) bus.tl_data = $urandom;
      bus.tl_mul         = $urandom;
      bus.tl_r2          = $urandom;
      bus.tl_dst         = 5'($urandom);
      bus.tl_isequal     = 1'($urandom);
      {bus.tl_flag_mem, bus.tl_flag_store, bus.tl_flag_isbyte, bus.tl_flag_mul,
       bus.tl_flag_reg, bus.tl_flag_jump, bus.tl_flag_branch, bus.tl_flag_iret} = 8'($urandom);
      case ($urandom_range(0, 2))
        0:       bus.tl_flag_tlbwrite = TLBW_OFF;
        1:       bus.tl_flag_tlbwrite = TLBW_ITLB;
        default: bus.tl_flag_tlbwrite = TLBW_DTLB;
      endcase
      bus.tl_priv  = ($urandom_range(0, 9) == 0);
      bus.c_stall  = ($urandom_range(0, 4) == 0);
      bus.tl_flush = ($urandom_range(0, 9) == 0);
      rst          = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;

    // Reset mid-stream discards the in-flight instruction and every mapping.
    set_wr(32'h0000_B000, 32'hBB); step();
    set_load(32'h0000_B004, 1'b0);
    rst = 1'b1; step();
    check("mid_rst_valid", bus.c_isvalid, 1'b0);
    check("mid_rst_paddr", bus.c_paddr, 20'h0);
    rst = 1'b0; step();
    check("post_rst_miss", bus.c_dtlb_miss, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
